// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive front end.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  // Clock cycles per oversample tick, rounded to nearest and never below 1.
  function automatic int calc_div(input int clock_freq, input int baud, input int oversample);
    longint denom;
    longint quot;
    denom = longint'(baud) * longint'(oversample);
    quot  = (longint'(clock_freq) + denom / 2) / denom;
    return (quot < 1) ? 1 : int'(quot);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head outputs; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      wr_ptr_n;
  logic [AW:0]      rd_ptr_n;
  logic             do_push;
  logic             do_pop;
  logic [WIDTH-1:0] head_n;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign wr_ptr_n = do_push ? (wr_ptr + PTR_ONE) : wr_ptr;
  assign rd_ptr_n = do_pop ? (rd_ptr + PTR_ONE) : rd_ptr;

  // The next head may be the word being written this cycle (write-through).
  always_comb begin
    head_n = mem[rd_ptr_n[AW-1:0]];
    if (do_push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
      head_n = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      head_valid <= (wr_ptr_n != rd_ptr_n);
      if (wr_ptr_n != rd_ptr_n) begin
        head_data <= head_n;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchroniser, oversampling tick generator, receive FSM
// and a small output FIFO presented as a valid/ready stream.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int DIV = calc_div(CLOCK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [DW-1:0] DIV_LAST    = DW'(DIV - 1);
  localparam logic [SW-1:0] SAMPLE_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DATA_BITS - 1);

  rx_state_e            state;
  rx_state_e            state_n;
  logic                 rx_meta;
  logic                 rxs;
  logic [DW-1:0]        dcnt;
  logic                 tick;
  logic                 leave_idle;
  logic [SW-1:0]        scnt;
  logic [SW-1:0]        scnt_n;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_cnt_n;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_n;
  logic                 push_byte;
  logic                 frame_err_n;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  // Both stages reset high so a reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick       = (dcnt == DIV_LAST);
  assign leave_idle = (state == IDLE) && (state_n != IDLE);

  // Restarting the divider on the start edge aligns bit timing to that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
    end else if (leave_idle || tick) begin
      dcnt <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  always_comb begin
    state_n     = state;
    scnt_n      = scnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    push_byte   = 1'b0;
    frame_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!rxs) begin
          state_n = START;
          scnt_n  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == SAMPLE_MID) begin
            scnt_n    = '0;
            bit_cnt_n = '0;
            state_n   = rxs ? IDLE : DATA;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == SAMPLE_LAST) begin
            scnt_n    = '0;
            shreg_n   = {rxs, shreg[DATA_BITS-1:1]};
            bit_cnt_n = bit_cnt + BW'(1);
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (scnt == SAMPLE_LAST) begin
            scnt_n = '0;
            if (rxs) begin
              push_byte = 1'b1;
              state_n   = IDLE;
            end else begin
              frame_err_n = 1'b1;
              state_n     = BREAK;
            end
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
      end
      BREAK: begin
        if (rxs) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scnt      <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      bit_cnt   <= bit_cnt_n;
      shreg     <= shreg_n;
      frame_err <= frame_err_n;
      overrun   <= push_byte && fifo_full && !fifo_pop;
    end
  end

  assign busy     = (state != IDLE);
  assign fifo_pop = m_ready && !fifo_empty;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_byte),
    .push_data (shreg),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head_data (m_data),
    .head_valid(m_valid)
  );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed self-checking bench for uart_rx_frontend at 16 clock cycles per bit.
module tb_uart_rx_frontend;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t0;

  int         vhigh = 0;
  int         rise_cyc = -1;
  int         ferr_cnt = 0;
  int         ovr_cnt = 0;
  int         ovr_cyc = -1;
  int         busy_run = 0;
  int         busy_max = 0;
  int         stable_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_ready = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [7:0] got [$];
  logic [11:0] rst_snap;

  uart_rx_frontend #(
    .CLOCK_FREQ(100_000_000),
    .BAUD_RATE (6_250_000),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (rxd),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stream observer: counts pulses, logs accepted bytes, tracks busy runs.
  always @(negedge clk) begin
    if (m_valid) vhigh++;
    if (m_valid && !prev_valid) rise_cyc = cyc;
    if (m_valid && m_ready) got.push_back(m_data);
    if (prev_valid && !prev_ready && m_valid && (m_data !== prev_data)) stable_err++;
    if (frame_err) ferr_cnt++;
    if (overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (busy) begin
      busy_run++;
      if (busy_run > busy_max) busy_max = busy_run;
    end else begin
      busy_run = 0;
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_data  = m_data;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] got_at(input int idx);
    return (got.size() > idx) ? {24'h0, got[idx]} : 32'hFFFF_FFFF;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, one cycle per iteration; optionally pulses m_ready or rst at a frame offset.
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_val,
                                input int ready_at, input int rst_at);
    logic [9:0] frame;
    frame = {stop_val, data, 1'b0};
    for (int c = 0; c < 10 * OS; c++) begin
      rxd = frame[c / OS];
      if (ready_at >= 0) m_ready = (c == ready_at);
      if (rst_at >= 0) begin
        if (c == rst_at) rst = 1'b1;
        if (c == rst_at + 2) rst_snap = {m_data, m_valid, frame_err, overrun, busy};
        if (c == rst_at + 4) rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst     = 1'b1;
    rxd     = 1'b1;
    m_ready = 1'b0;
    wait_cycles(3);
    check_output("reset_m_data", {24'h0, m_data}, 32'h0);
    check_output("reset_m_valid", {31'h0, m_valid}, 32'h0);
    check_output("reset_frame_err", {31'h0, frame_err}, 32'h0);
    check_output("reset_overrun", {31'h0, overrun}, 32'h0);
    check_output("reset_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
    wait_cycles(5);

    // Single byte 0xA5 with consumer always ready
    m_ready = 1'b1;
    got.delete();
    vhigh = 0; rise_cyc = -1; ferr_cnt = 0; ovr_cnt = 0;
    t0 = cyc;
    apply_stimulus(8'hA5, 1'b1, -1, -1);
    wait_cycles(10);
    check_output("a5_latency_155pm1", {31'h0, (rise_cyc - t0 >= 154) && (rise_cyc - t0 <= 156)}, 32'h1);
    check_output("a5_valid_cycles", vhigh, 1);
    check_output("a5_count", got.size(), 1);
    check_output("a5_data", got_at(0), 32'hA5);
    check_output("a5_frame_err", ferr_cnt, 0);
    check_output("a5_overrun", ovr_cnt, 0);

    // Short low glitch must be rejected at mid-start
    busy_max = 0; vhigh = 0;
    rxd = 1'b0;
    wait_cycles(4);
    rxd = 1'b1;
    wait_cycles(30);
    check_output("glitch_busy_len", {31'h0, (busy_max >= 1) && (busy_max <= 12)}, 32'h1);
    check_output("glitch_busy_end", {31'h0, busy}, 32'h0);
    check_output("glitch_no_valid", vhigh, 0);
    check_output("glitch_no_ferr", ferr_cnt, 0);

    // Framing error: 0x3C with low stop bit, line held low 40 cycles
    got.delete(); vhigh = 0; ferr_cnt = 0;
    apply_stimulus(8'h3C, 1'b0, -1, -1);
    wait_cycles(24);
    check_output("break_busy_held", {31'h0, busy}, 32'h1);
    rxd = 1'b1;
    wait_cycles(20);
    check_output("ferr_once", ferr_cnt, 1);
    check_output("ferr_no_valid", vhigh, 0);
    check_output("ferr_idle_after", {31'h0, busy}, 32'h0);
    apply_stimulus(8'h55, 1'b1, -1, -1);
    wait_cycles(10);
    check_output("after_ferr_count", got.size(), 1);
    check_output("after_ferr_data", got_at(0), 32'h55);
    check_output("after_ferr_no_new_ferr", ferr_cnt, 1);

    // Overrun: five bytes into a four-entry FIFO with no consumer
    m_ready = 1'b0;
    got.delete(); ovr_cnt = 0; ovr_cyc = -1;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) t0 = cyc;
      apply_stimulus(8'(i), 1'b1, -1, -1);
    end
    wait_cycles(5);
    check_output("ovr_once", ovr_cnt, 1);
    check_output("ovr_in_stop_bit", {31'h0, (ovr_cyc - t0 >= 145) && (ovr_cyc - t0 <= 160)}, 32'h1);
    check_output("ovr_valid_held", {31'h0, m_valid}, 32'h1);
    check_output("ovr_head_data", {24'h0, m_data}, 32'h01);
    m_ready = 1'b1;
    wait_cycles(10);
    check_output("ovr_drain_count", got.size(), 4);
    check_output("ovr_drain_0", got_at(0), 32'h01);
    check_output("ovr_drain_1", got_at(1), 32'h02);
    check_output("ovr_drain_2", got_at(2), 32'h03);
    check_output("ovr_drain_3", got_at(3), 32'h04);
    check_output("ovr_empty_after", {31'h0, m_valid}, 32'h0);

    // Full FIFO with a pop in the same cycle as the fifth push
    m_ready = 1'b0;
    wait_cycles(2);
    got.delete(); ovr_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      apply_stimulus(8'(i), 1'b1, (i == 5) ? 154 : -1, -1);
    end
    wait_cycles(5);
    check_output("simul_no_overrun", ovr_cnt, 0);
    check_output("simul_popped_first", got_at(0), 32'h01);
    m_ready = 1'b1;
    wait_cycles(10);
    check_output("simul_total", got.size(), 5);
    check_output("simul_drain_0", got_at(1), 32'h02);
    check_output("simul_drain_1", got_at(2), 32'h03);
    check_output("simul_drain_2", got_at(3), 32'h04);
    check_output("simul_drain_3", got_at(4), 32'h05);

    // Reset in data bit 3 of 0xFF with one byte already buffered
    m_ready = 1'b0;
    wait_cycles(2);
    got.delete(); ferr_cnt = 0; ovr_cnt = 0;
    apply_stimulus(8'h42, 1'b1, -1, -1);
    wait_cycles(5);
    check_output("pre_reset_valid", {31'h0, m_valid}, 32'h1);
    apply_stimulus(8'hFF, 1'b1, -1, 70);
    check_output("reset_midframe_outputs", {20'h0, rst_snap}, 32'h0);
    wait_cycles(5);
    check_output("post_reset_valid", {31'h0, m_valid}, 32'h0);
    check_output("post_reset_busy", {31'h0, busy}, 32'h0);
    m_ready = 1'b1;
    apply_stimulus(8'h81, 1'b1, -1, -1);
    wait_cycles(10);
    check_output("post_reset_count", got.size(), 1);
    check_output("post_reset_data", got_at(0), 32'h81);
    check_output("post_reset_no_flags", ferr_cnt + ovr_cnt, 0);
    check_output("data_stable_while_stalled", stable_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial-to-byte receive stage that sits directly upstream of the shell's host-side logic.
- Takes the raw board UART input (8N1, idle high) and synchronises it.
- Recovers bytes by oversampling and buffers them in a small FIFO.
- Presents bytes on a valid/ready stream to the consuming logic, with pulsed error flags for diagnostic LEDs.

Parameters:
- CLOCK_FREQ, 100_000_000: input clock frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 4.
- FIFO_DEPTH, 4: receive buffer entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; asynchronous, active-high.
- rxd  in  1  raw serial input, asynchronous to clk, idle high.
- m_data  out  8  received byte at FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: byte dropped because FIFO full.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
Reset values:
- m_valid=0, m_data=0, frame_err=0, overrun=0, busy=0.
- FIFO empty; FSM in IDLE.
- Both synchroniser flops reset to 1 (line idle).

Synchroniser:
- 2-flop chain on rxd; rxs denotes the second-stage output.
- All decisions use rxs only.

Tick generator:
- DIV = round(CLOCK_FREQ/(BAUD_RATE*OVERSAMPLE)), minimum 1.
- Counter pulses tick every DIV cycles.
- Free-running, but cleared whenever the FSM leaves IDLE, so bit timing is aligned to the start edge.

Sample counter:
- scnt counts ticks 0..OVERSAMPLE-1 within a bit.
- Mid-bit sample point is scnt==OVERSAMPLE/2-1 in START.
- Bit boundary is scnt==OVERSAMPLE-1 in DATA/STOP.

FSM (IDLE, START, DATA, STOP, BREAK):
- IDLE: rxs==0 → START, scnt=0.
- START: at mid-bit, rxs==0 → DATA with scnt=0 (all later samples are mid-bit); rxs==1 → IDLE (glitch reject, no flags).
- DATA: every OVERSAMPLE ticks, sample rxs into the shift register, LSB first. After the 8th bit → STOP.
- STOP: after OVERSAMPLE ticks, sample rxs.
  - 1: push the byte → IDLE.
  - 0: pulse frame_err, discard the byte → BREAK.
- BREAK: wait for rxs==1 → IDLE. A line held low never produces repeated frames.
- Returning to IDLE at mid-stop lets a start bit arriving early be detected.

FIFO:
- Push on a valid stop bit; pop on m_valid && m_ready.
- Push when full:
  - Without a same-cycle pop: byte dropped, overrun pulses, stored contents unchanged.
  - With a same-cycle pop: both occur, no overrun.
- Pop when empty is ignored.
- m_data/m_valid are registered from FIFO state. m_valid rises the cycle after the push.
- m_data is stable while m_valid && !m_ready.
- Pointers use log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB compare.

Latency:
- m_valid rises 2 (sync) + START/DATA/STOP sampling time + 1 cycles after the rxd falling edge.
- This is (9.5 bits)·OVERSAMPLE·DIV + 3 cycles, ±1 tick.

Reset mid-frame:
- Abandons the frame, empties the FIFO, emits no flags.
- After release, a low rxd is treated as a new start bit.

Decomposition:
- Package uart_pkg holds:
  - the state enum rx_state_e (IDLE, START, DATA, STOP, BREAK);
  - localparam DATA_BITS=8;
  - function calc_div(clock_freq, baud, oversample) with rounding and min 1.
- Natural sub-module: sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty and the simultaneous-push-pop-when-full rule above.
- Tick generator, synchroniser and FSM stay in uart_rx_frontend.

Test Plan:
Bench parameters: CLOCK_FREQ=100_000_000, BAUD_RATE=6_250_000, OVERSAMPLE=16, which gives DIV=1 and 16 cycles per bit.
- Single byte 0xA5, m_ready=1: m_data=0xA5, m_valid high exactly 1 cycle, asserted 155±1 cycles after the rxd falling edge; frame_err=overrun=0.
- Glitch: rxd low for 4 cycles, then high: no m_valid, no flags, busy high at most 12 cycles and then 0.
- Framing: send 0x3C with stop bit 0, hold rxd low 40 cycles, then high: frame_err pulses once, no m_valid. A following 0x55 is received correctly.
- Overrun: m_ready=0, send 0x01..0x05 back-to-back:
  - overrun pulses once, during the 5th stop bit;
  - then m_ready=1 drains 0x01,0x02,0x03,0x04 in order, and m_valid falls after 4 pops.
- Full plus simultaneous pop: FIFO full, m_ready pulsed in the same cycle as the 5th push: no overrun; subsequent drain yields bytes 2..5.
- Reset mid-frame: assert rst during DATA bit 3 of 0xFF: all outputs 0 during reset, no byte delivered. A subsequent 0x81 is received correctly.
